i2c_reg_responder: RTL and testbench
====================================

// Module: i2c_reg_responder
// PURPOSE
//   I2C target (responder) that receives 3-byte register-write frames: device address byte
//   plus two data bytes, in WM8731 format ({reg[6:0],data[8]},{data[7:0]}). It is the far end
//   of the codec-config I2C sender and is used as an on-chip codec stand-in and as a loopback
//   checker for sender traffic. Write-only. Each complete frame is reported as one parallel
//   register write.
// PARAMETERS
//   DEV_ADDR  7'h1A  7-bit target address; write address byte is 8'h34
//   SYNC_LEN  2      synchronizer flops on i_sclk / io_sdat, before the edge-detect register
// PORTS
//   i_clk        in   1  system clock; must run at >= 8x the SCL rate
//   i_rst        in   1  synchronous, active-high reset
//   i_sclk       in   1  I2C SCL from the bus (asynchronous)
//   io_sdat      inout 1 I2C SDA, open-drain: drives 0 or releases 'z'
//   o_reg_addr   out  7  register address of the last complete frame
//   o_reg_data   out  9  register data of the last complete frame
//   o_reg_valid  out  1  one-cycle pulse: o_reg_addr/o_reg_data updated this cycle
//   o_busy       out  1  high from an address-matched START until STOP or reset
// BEHAVIOUR
//   - Reset (i_rst sampled high at posedge i_clk): state S_IDLE; SDA released (oe=0).
//     All outputs are 0. Counters and shift register are 0. Reset mid-frame releases SDA
//     on the next cycle.
//   - Line handling: SCL and SDA pass through SYNC_LEN flops plus one previous-value
//     register. Let scl/sda be the synchronized values.
//       rise = SCL rising edge; fall = SCL falling edge.
//       START = sda falling while scl=1; STOP = sda rising while scl=1.
//   - Data timing: bits are sampled MSB-first on rise. SDA drive changes only on fall.
//   - States: S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE.
//   - START (including repeated START) in any state: go to S_ADDR.
//     bit_cnt=0, byte_idx=0, SDA released, o_busy=0.
//   - STOP in any state: go to S_IDLE, SDA released, o_busy=0. An incomplete frame is
//     discarded with no o_reg_valid.
//   - S_ADDR: shift in 8 bits. On the fall after bit 8:
//       * {DEV_ADDR,1'b0} match: drive SDA=0, set o_busy=1, go to S_ADDR_ACK.
//       * any other address, or R/W=1: keep SDA released (NACK), go to S_IGNORE.
//   - S_ADDR_ACK / S_DATA_ACK: hold SDA=0 through the ack clock. Release on the next fall.
//     Then enter S_DATA with bit_cnt=0.
//   - S_DATA: shift 8 bits; bit_cnt is 3 bits and wraps 7->0 at byte end.
//       * byte_idx=0: keep the byte, ACK, byte_idx=1.
//       * byte_idx=1: on the rise of bit 8, load o_reg_addr=byte0[7:1] and
//         o_reg_data={byte0[0],byte1}. Pulse o_reg_valid on the following cycle.
//         ACK, then byte_idx=2.
//       * byte_idx=2 (third or later byte): NACK (release), go to S_IGNORE.
//   - S_IGNORE: SDA never driven; only START or STOP leave this state.
//   - Simultaneous events: START/STOP detection takes priority over any rise/fall action in
//     the same cycle. o_reg_valid is never asserted during reset.
//   - Latency: o_reg_valid occurs SYNC_LEN+2 i_clk cycles after the SCL rise of the last
//     data bit. o_reg_* hold their value until the next valid frame.
// STRUCTURE
//   - Shared package i2c_pkg:
//       * enum I2cRxState for the states above;
//       * constants WM8731_ADDR=7'h1A and I2C_WRITE=1'b0, also used by the sender.
//   - Sub-module i2c_line_sync: SYNC_LEN synchronizer plus edge detect for one line.
//     Instantiated twice, for SCL and SDA; outputs level, rise, fall.
//   - Top level holds the FSM, bit_cnt, byte_idx, 8-bit shift register, byte0 register,
//     and the registered oe. Assign io_sdat = oe ? 1'b0 : 1'bz.
// TESTING
//   1) Frame 34,1E,00 at 100 kHz SCL, 50 MHz clk: ACK (SDA=0) on all 3 ninth clocks,
//      one o_reg_valid pulse with addr=7'h0F, data=9'h000.
//   2) Frame 34,08,12: addr=7'h04, data=9'h012. Then 34,0D,FF: addr=7'h06, data=9'h1FF.
//   3) Address byte 36 or 35: SDA released on the ninth clock, o_busy stays 0,
//      no o_reg_valid for the following data bytes.
//   4) 34,1E then STOP: two ACKs, no valid, o_busy falls after STOP.
//      Outputs keep the previous frame's values.
//   5) 34,04 + repeated START mid-byte + 34,0A,05: exactly one valid, addr=7'h05, data=9'h005.
//   6) 34,1E,00,AA: third data byte NACKed, single valid. Assert i_rst during an ACK:
//      SDA goes 'z' next cycle, all outputs return to 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the codec-config sender and the register responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  // Responder frame-tracking states
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } I2cRxState;

  // WM8731 7-bit bus address and the R/W bit value for a write
  localparam logic [6:0] WM8731_ADDR = 7'h1A;
  localparam logic       I2C_WRITE   = 1'b0;

  // True when an address byte selects this target for a write
  function automatic logic is_write_to(input logic [7:0] addr_byte, input logic [6:0] dev);
    return addr_byte == {dev, I2C_WRITE};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes one asynchronous I2C line and flags its edges.
// Latency: level/edge visible SYNC_LEN i_clk cycles after the pin changes.
// Backpressure: none; edges are single-cycle strobes.
module i2c_line_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_LEN-1:0] sync_q;
  logic                prev_q;

  // Synchronizer chain plus previous-value register; idle bus level is high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_LEN-2:0], i_line};
      prev_q <= sync_q[SYNC_LEN-1];
    end
  end

  assign o_level = sync_q[SYNC_LEN-1];
  assign o_rise  = o_level & ~prev_q;
  assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C write-only target decoding 3-byte WM8731 frames into parallel register writes.
// Latency: o_reg_valid pulses SYNC_LEN+2 i_clk cycles after the SCL rise of the last data bit.
// Backpressure: none; the consumer must take the one-cycle o_reg_valid pulse.
module i2c_reg_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = WM8731_ADDR,
  parameter int         SYNC_LEN = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  inout  wire        io_sdat,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_reg_valid,
  output logic       o_busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_det, stop_det;

  I2cRxState  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte0_q, byte0_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [8:0] reg_data_q, reg_data_d;
  logic       load_q, load_d;
  logic       valid_q;

  i2c_line_sync #(.SYNC_LEN(SYNC_LEN)) u_scl_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_line  (i_sclk),
    .o_level (scl),
    .o_rise  (scl_rise),
    .o_fall  (scl_fall)
  );

  i2c_line_sync #(.SYNC_LEN(SYNC_LEN)) u_sda_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_line  (io_sdat),
    .o_level (sda),
    .o_rise  (sda_rise),
    .o_fall  (sda_fall)
  );

  // Bus conditions: SDA moving while SCL is high frames a transfer
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      byte_idx_q  <= '0;
      byte_done_q <= 1'b0;
      shift_q     <= '0;
      byte0_q     <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      load_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      byte0_q     <= byte0_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      load_q      <= load_d;
      valid_q     <= load_q;
    end
  end

  // Next-state logic: START/STOP override any SCL-edge action in the same cycle
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    byte0_d     = byte0_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    load_d      = 1'b0;

    if (start_det) begin
      state_d     = S_ADDR;
      bit_cnt_d   = '0;
      byte_idx_d  = '0;
      byte_done_d = 1'b0;
      oe_d        = 1'b0;
      busy_d      = 1'b0;
    end else if (stop_det) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      byte_idx_d  = '0;
      byte_done_d = 1'b0;
      oe_d        = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              // Second data byte complete: the register write is known now
              if (state_q == S_DATA && byte_idx_q == 2'd1) begin
                reg_addr_d = byte0_q[7:1];
                reg_data_d = {byte0_q[0], shift_q[6:0], sda};
                load_d     = 1'b1;
              end
            end
          end else if (scl_fall && byte_done_q) begin
            // Falling edge after the eighth bit: decide ACK or NACK
            byte_done_d = 1'b0;
            if (state_q == S_ADDR) begin
              if (is_write_to(shift_q, DEV_ADDR)) begin
                oe_d    = 1'b1;
                busy_d  = 1'b1;
                state_d = S_ADDR_ACK;
              end else begin
                oe_d    = 1'b0;
                state_d = S_IGNORE;
              end
            end else begin
              case (byte_idx_q)
                2'd0: begin
                  byte0_d    = shift_q;
                  byte_idx_d = 2'd1;
                  oe_d       = 1'b1;
                  state_d    = S_DATA_ACK;
                end
                2'd1: begin
                  byte_idx_d = 2'd2;
                  oe_d       = 1'b1;
                  state_d    = S_DATA_ACK;
                end
                default: begin
                  oe_d    = 1'b0;
                  state_d = S_IGNORE;
                end
              endcase
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          // ACK held low through the ninth clock, released as it falls
          if (scl_fall) begin
            oe_d        = 1'b0;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            state_d     = S_DATA;
          end
        end
        default: begin
          oe_d = 1'b0;
        end
      endcase
    end
  end

  assign io_sdat     = oe_q ? 1'b0 : 1'bz;
  assign o_reg_addr  = reg_addr_q;
  assign o_reg_data  = reg_data_q;
  assign o_reg_valid = valid_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Bench acting as I2C controller; scoreboard derives ACKs and register writes from frame bytes.
// Latency: checks o_reg_valid timing against the last data-bit SCL rise.
// Backpressure: n/a.
module tb_i2c_reg_responder;

  localparam int          SYNC_LEN = 2;
  localparam logic [7:0]  WR_ADDR  = 8'h34;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda_bus;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       reg_valid;
  logic       busy;

  pullup (sda_bus);
  assign sda_bus = sda_low ? 1'b0 : 1'bz;

  i2c_reg_responder #(.DEV_ADDR(7'h1A), .SYNC_LEN(SYNC_LEN)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sclk      (scl),
    .io_sdat     (sda_bus),
    .o_reg_addr  (reg_addr),
    .o_reg_data  (reg_data),
    .o_reg_valid (reg_valid),
    .o_busy      (busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q = 8;
  int cyc = 0;
  int rise_cyc = 0;
  logic [15:0] vq[$];
  logic [7:0]  fb[8];
  logic [6:0]  last_addr = '0;
  logic [8:0]  last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every register-write pulse and check its distance from the last data-bit rise
  always @(negedge clk) begin
    if (reg_valid) begin
      vq.push_back({reg_addr, reg_data});
      checks++;
      if (cyc - rise_cyc != SYNC_LEN + 2) begin
        errors++;
        $display("FAIL valid_latency: got %0d cycles want %0d", cyc - rise_cyc, SYNC_LEN + 2);
      end
      if (rst) begin
        errors++;
        $display("FAIL valid_in_reset: got 1 want 0");
      end
    end
  end

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard rule: a frame addressed 0x34 is ACKed for the address and two data bytes
  function automatic bit model_ack(input logic [7:0] first, input int k);
    return (first == WR_ADDR) && (k <= 2);
  endfunction

  task automatic wait_q();
    repeat (q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    sda_low = 1'b1; wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wait_q();
    scl = 1'b1;     wait_q();
    sda_low = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b; wait_q();
    scl = 1'b1;
    rise_cyc = cyc;
    wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic read_ack(output bit acked);
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    acked = (sda_bus === 1'b0);
    wait_q();
    scl = 1'b0;     wait_q();
  endtask

  // Sends fb[0..n-1] after a (repeated) START and scores ACKs, busy, writes and held outputs
  task automatic run_frame(input string name, input int n, input bit stop);
    bit acked;
    bit match;
    bit exp_v;
    match = (fb[0] == WR_ADDR);
    i2c_start();
    for (int i = 0; i < n; i++) begin
      send_byte(fb[i]);
      read_ack(acked);
      checks++;
      if (acked !== model_ack(fb[0], i)) begin
        errors++;
        $display("FAIL %s ack[%0d]: got %0b want %0b", name, i, acked, model_ack(fb[0], i));
      end
      if (i == 0) begin
        checks++;
        if (busy !== match) begin
          errors++;
          $display("FAIL %s busy_after_addr: got %0b want %0b", name, busy, match);
        end
      end
    end
    if (stop) i2c_stop();
    repeat (8) @(negedge clk);
    exp_v = match && (n >= 3);
    if (exp_v) begin
      last_addr = fb[1][7:1];
      last_data = {fb[1][0], fb[2]};
    end
    checks++;
    if (vq.size() != (exp_v ? 1 : 0)) begin
      errors++;
      $display("FAIL %s valid_count: got %0d want %0d", name, vq.size(), exp_v ? 1 : 0);
    end
    checks++;
    if ({reg_addr, reg_data} !== {last_addr, last_data}) begin
      errors++;
      $display("FAIL %s reg_out: got %h/%h want %h/%h", name, reg_addr, reg_data, last_addr, last_data);
    end
    if (stop) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_after_stop: got %0b want 0", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({reg_addr, reg_data, reg_valid, busy} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%h/%0b/%0b want 0", reg_addr, reg_data, reg_valid, busy);
    end
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL reset_sda: got %0b want 1", sda_bus);
    end
  endtask

  task automatic test_frame_100k();
    q = 125;
    vq.delete();
    fb[0] = 8'h34; fb[1] = 8'h1E; fb[2] = 8'h00;
    run_frame("frame_100k", 3, 1'b1);
    q = 8;
  endtask

  task automatic test_frames();
    vq.delete();
    fb[0] = 8'h34; fb[1] = 8'h08; fb[2] = 8'h12;
    run_frame("frame_08_12", 3, 1'b1);
    vq.delete();
    fb[0] = 8'h34; fb[1] = 8'h0D; fb[2] = 8'hFF;
    run_frame("frame_0d_ff", 3, 1'b1);
  endtask

  task automatic test_bad_addr();
    vq.delete();
    fb[0] = 8'h36; fb[1] = 8'h1E; fb[2] = 8'h00;
    run_frame("addr_36", 3, 1'b1);
    vq.delete();
    fb[0] = 8'h35; fb[1] = 8'h1E; fb[2] = 8'h00;
    run_frame("addr_35", 3, 1'b1);
  endtask

  task automatic test_abort();
    vq.delete();
    fb[0] = 8'h34; fb[1] = 8'h1E;
    run_frame("abort", 2, 1'b1);
  endtask

  task automatic test_repeated_start();
    bit acked;
    vq.delete();
    i2c_start();
    send_byte(8'h34); read_ack(acked);
    send_byte(8'h04); read_ack(acked);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    fb[0] = 8'h34; fb[1] = 8'h0A; fb[2] = 8'h05;
    run_frame("repeated_start", 3, 1'b1);
  endtask

  task automatic test_extra_byte();
    vq.delete();
    fb[0] = 8'h34; fb[1] = 8'h1E; fb[2] = 8'h00; fb[3] = 8'hAA;
    run_frame("extra_byte", 4, 1'b1);
  endtask

  task automatic test_reset_in_ack();
    vq.delete();
    i2c_start();
    send_byte(8'h34);
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    checks++;
    if (sda_bus !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack_driven: got %0b want 0", sda_bus);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL rst_sda_release: got %0b want 1", sda_bus);
    end
    checks++;
    if ({reg_addr, reg_data, reg_valid, busy} !== 18'd0) begin
      errors++;
      $display("FAIL rst_outputs: got %h/%h/%0b/%0b want 0", reg_addr, reg_data, reg_valid, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_addr = '0;
    last_data = '0;
    wait_q();
    scl = 1'b0; wait_q();
    i2c_stop();
    repeat (8) @(negedge clk);
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL rst_no_valid: got %0d want 0", vq.size());
    end
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 12; f++) begin
      q = $urandom_range(6, 10);
      n = $urandom_range(1, 4);
      fb[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : WR_ADDR;
      for (int i = 1; i < 8; i++) fb[i] = 8'($urandom);
      vq.delete();
      run_frame($sformatf("random%0d", f), n, 1'b1);
    end
    q = 8;
  endtask

  initial begin
    test_reset();
    test_frame_100k();
    test_frames();
    test_bad_addr();
    test_abort();
    test_repeated_start();
    test_extra_byte();
    test_reset_in_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
